// File: rtl/lzw_code_packer.sv
// -----------------------------------------------------------------------------
// lzw_code_packer
//
// Packs variable-width LZW codes LSB-first into fixed OUT_W-bit words. Codes
// are appended to an accumulator at the current fill position. Whenever a full
// word is available and the output slot is free, it moves into a single output
// register. A flush request drains the remaining bits as a final, possibly
// partial, word marked out_last. A flush with nothing buffered produces a
// zero-length terminator word.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   a code is offered
//   in_ready   a code can be accepted this cycle (combinational)
//   in_code    code value, LSB-aligned
//   in_width   number of valid low bits of in_code (0..CODE_W)
//   flush      single-cycle request to emit all buffered bits and end stream
//   out_valid  out_data / out_bits / out_last are valid
//   out_ready  consumer accepts the output word
//   out_data   packed bits, first code at bit 0
//   out_bits   number of meaningful bits in out_data (0..OUT_W)
//   out_last   final word of a flushed stream
//   idle       RUN state, empty accumulator, no pending output
// -----------------------------------------------------------------------------
module lzw_code_packer #(
  parameter int CODE_W = 13,
  parameter int OUT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [3:0]        in_width,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [6:0]        out_bits,
  output logic              out_last,
  output logic              idle
);

  localparam int ACC_W  = OUT_W + CODE_W;
  localparam int FILL_W = $clog2(ACC_W);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [6:0]         r_out_bits;
  logic               r_out_last;

  logic               w_slot_free;
  logic               w_accept;
  logic               w_load_full;
  logic               w_load_last;
  logic [CODE_W-1:0]  w_code_mask;
  logic [ACC_W-1:0]   w_code_ins;
  logic [FILL_W-1:0]  w_fill_add;

  assign w_slot_free = !r_out_valid || out_ready;

  // Input is only taken below one word of fill, so appending and emitting a
  // word are mutually exclusive within a cycle.
  assign in_ready = !rst && (r_state == S_RUN) && (r_fill < OUT_W_F);
  assign w_accept = in_valid && in_ready;

  // In RUN a word leaves as soon as fill reaches OUT_W. In FLUSH exactly OUT_W
  // bits go out as the last word rather than a full word followed by an
  // empty terminator.
  assign w_load_full = w_slot_free &&
                       (((r_state == S_RUN)   && (r_fill >= OUT_W_F)) ||
                        ((r_state == S_FLUSH) && (r_fill >  OUT_W_F)));
  assign w_load_last = w_slot_free && (r_state == S_FLUSH) && (r_fill <= OUT_W_F);

  // Masking bits at or above in_width keeps every accumulator bit above fill at
  // zero. That lets the final partial word be taken straight from the low bits.
  assign w_code_mask = ~({CODE_W{1'b1}} << in_width);
  assign w_code_ins  = {{OUT_W{1'b0}}, in_code & w_code_mask} << r_fill;
  assign w_fill_add  = r_fill + FILL_W'(in_width);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the accumulator is reset along with the control state. Bits left
      // above fill would otherwise leak into the first partial word.
      r_state     <= S_RUN;
      r_acc       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bits  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      // Handshake retires the current word; a same-cycle load below wins.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_load_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_acc[OUT_W-1:0];
        r_out_bits  <= 7'(OUT_W);
        r_out_last  <= 1'b0;
        r_acc       <= r_acc >> OUT_W;
        r_fill      <= r_fill - OUT_W_F;
      end else if (w_load_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_acc[OUT_W-1:0];
        r_out_bits  <= 7'(r_fill);
        r_out_last  <= 1'b1;
        r_acc       <= '0;
        r_fill      <= '0;
      end else if (w_accept) begin
        r_acc       <= r_acc | w_code_ins;
        r_fill      <= w_fill_add;
      end

      case (r_state)
        S_RUN: begin
          if (flush) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_load_last) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bits  = r_out_bits;
  assign out_last  = r_out_last;
  assign idle      = !rst && (r_state == S_RUN) && (r_fill == '0) && !r_out_valid;

endmodule

// File: tb/tb_lzw_code_packer.sv
module tb_lzw_code_packer;

  localparam int CODE_W = 13;
  localparam int OUT_W  = 64;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [3:0]        in_width;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [6:0]        out_bits;
  logic              out_last;
  logic              idle;

  lzw_code_packer #(.CODE_W(CODE_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_width  (in_width),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  bits;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    n_compared   = 0;
  int    n_mismatched = 0;

  // Directed 13-bit code stream used by the back-pressure and reset tests.
  logic [12:0] s_codes [12] = '{13'h1ABC, 13'h0123, 13'h1F0F, 13'h0AAA,
                                13'h1555, 13'h0F0F, 13'h1234, 13'h0765,
                                13'h1FED, 13'h0CBA, 13'h1357, 13'h0468};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference packing: global bit p is bit (p % 13) of code (p / 13).
  function automatic logic [63:0] model_word(input int idx, input int n_codes);
    logic [63:0] w;
    int p;
    w = '0;
    for (int j = 0; j < 64; j++) begin
      p = idx * 64 + j;
      if (p < n_codes * 13) w[j] = s_codes[p / 13][p % 13];
    end
    return w;
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic [6:0] b, input logic l);
    word_t w;
    w.data = d;
    w.bits = b;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [CODE_W-1:0] code, input logic [3:0] width, input logic do_flush);
    int n;
    in_valid = 1'b1;
    in_code  = code;
    in_width = width;
    flush    = do_flush;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > BUDGET) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL send_timeout: in_ready stuck at 0 for code 0x%0h", code);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_only();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (idle && exp_q.size() == 0) break;
      n++;
      if (n > BUDGET) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL %s_idle_timeout: idle=%0b pending=%0d", name, idle, exp_q.size());
        break;
      end
    end
    tick();
  endtask

  // Monitor: every completed output handshake is compared against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_word: data=0x%0h bits=%0d last=%0b", out_data, out_bits, out_last);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("word_data", out_data, w.data);
        check("word_bits", 64'(out_bits), 64'(w.bits));
        check("word_last", 64'(out_last), 64'(w.last));
      end
    end
  end

  // Widths above CODE_W are illegal input.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      assert (in_width <= 4'(CODE_W))
        else $error("FAIL in_width_illegal: got %0d, limit %0d", in_width, CODE_W);
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    in_width  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bits",  64'(out_bits),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_idle",      64'(idle),      64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle",     64'(idle),     64'd1);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Two 9-bit codes then flush: 0x100 | 0x101<<9 = 0x20300
    push_exp(64'h20300, 7'd18, 1'b1);
    send(13'h100, 4'd9, 1'b0);
    send(13'h101, 4'd9, 1'b0);
    flush_only();
    wait_idle("two_codes");

    // Five 13-bit all-ones codes: one full word, then 1 leftover bit
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b0);
    push_exp(64'h1, 7'd1, 1'b1);
    for (int i = 0; i < 5; i++) send(13'h1FFF, 4'd13, 1'b0);
    flush_only();
    wait_idle("five_ones");

    // Width masking and zero-width no-op: 0xF | 0xA5<<4 = 0xA5F, 12 bits
    push_exp(64'hA5F, 7'd12, 1'b1);
    send(13'h1FFF, 4'd4, 1'b0);
    send(13'h1FFF, 4'd0, 1'b0);
    send(13'h10A5, 4'd8, 1'b0);
    flush_only();
    wait_idle("masking");

    // Flush with nothing buffered: zero-length terminator
    push_exp(64'h0, 7'd0, 1'b1);
    flush_only();
    wait_idle("empty_flush");
    @(negedge clk);
    check("empty_flush_idle", 64'(idle), 64'd1);
    tick();

    // Flush in the same cycle as a code into an empty packer
    push_exp(64'h1AB, 7'd9, 1'b1);
    send(13'h1AB, 4'd9, 1'b1);
    wait_idle("same_cycle_flush");

    // Back-pressure: first word must hold and input must stall at fill 66
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(s_codes[i], 4'd13, 1'b0);
    w0 = model_word(0, 12);
    repeat (2) @(negedge clk);
    check("bp_in_ready",  64'(in_ready),  64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_data_a",    out_data,       w0);
    repeat (4) @(negedge clk);
    check("bp_data_b",    out_data,       w0);
    check("bp_bits",      64'(out_bits),  64'd64);
    tick();
    push_exp(w0, 7'd64, 1'b0);
    push_exp(model_word(1, 12), 7'd64, 1'b0);
    push_exp(model_word(2, 12), 7'd28, 1'b1);
    out_ready = 1'b1;
    send(s_codes[10], 4'd13, 1'b0);
    send(s_codes[11], 4'd13, 1'b1);
    wait_idle("backpressure");

    // Reset during FLUSH with a pending word: everything discarded
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(s_codes[i], 4'd13, 1'b0);
    flush_only();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_flush_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_flush_rst_out_bits",  64'(out_bits),  64'd0);
    check("mid_flush_rst_idle",      64'(idle),      64'd1);
    tick();
    out_ready = 1'b1;
    push_exp(64'h155, 7'd9, 1'b1);
    send(13'h155, 4'd9, 1'b1);
    wait_idle("after_rst");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/lzw_code_packer.md
LZW_CODE_PACKER -- requirements
Module: lzw_code_packer

Interface
REQ-001 SHALL have parameter CODE_W, default 13, meaning the maximum code width in bits (dictionary index width + 1).
REQ-002 SHALL have parameter OUT_W, default 64, meaning the packed output word width in bits.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  meaning a code is offered.
REQ-006 SHALL have port in_ready  output  1  meaning a code can be accepted this cycle.
REQ-007 SHALL have port in_code  input  CODE_W  meaning the code value, LSB-aligned.
REQ-008 SHALL have port in_width  input  4  meaning the number of valid low bits of in_code, legal range 0..CODE_W.
REQ-009 SHALL have port flush  input  1  meaning a single-cycle request to emit all buffered bits and end the stream.
REQ-010 SHALL have port out_valid  output  1  meaning out_data, out_bits and out_last are valid.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer accepts the output word.
REQ-012 SHALL have port out_data  output  OUT_W  meaning the packed bits, with the first code at bit 0.
REQ-013 SHALL have port out_bits  output  7  meaning the count of meaningful bits in out_data, range 0..OUT_W.
REQ-014 SHALL have port out_last  output  1  meaning this is the final word of a flushed stream.
REQ-015 SHALL have port idle  output  1  meaning RUN state, empty accumulator, and no pending output.

Function
REQ-016 SHALL hold an accumulator of OUT_W+CODE_W bits plus a fill counter (0..OUT_W+CODE_W-1), and a single output register.
REQ-017 SHALL accept a code on in_valid && in_ready, appending in_code[in_width-1:0] at accumulator bit position fill (LSB-first) and adding in_width to fill; in_code bits at or above in_width SHALL be ignored.
REQ-018 SHALL treat in_width=0 as an accepted no-op; in_width>CODE_W is illegal, and the bench SHALL flag it as an assertion failure.
REQ-019 SHALL drive in_ready = !rst && state==RUN && fill<OUT_W, combinationally.
REQ-020 SHALL define the output slot as free when !out_valid || out_ready.
REQ-021 SHALL, in RUN with fill>=OUT_W and the slot free, load out_data=acc[OUT_W-1:0], out_bits=OUT_W and out_last=0, shift the accumulator right by OUT_W, and subtract OUT_W from fill, all in one cycle.
REQ-022 SHALL hold out_valid and all output fields stable until the out_valid && out_ready handshake; out_valid SHALL clear on that handshake unless a new word loads in the same cycle.
REQ-023 SHALL have FSM states RUN and FLUSH; reset enters RUN.
REQ-024 SHALL, on flush=1 in RUN, first apply any code accepted in the same cycle and then enter FLUSH; flush SHALL be ignored while in FLUSH.
REQ-025 SHALL accept no input while in FLUSH (in_ready=0).
REQ-026 SHALL, in FLUSH with the slot free and fill>OUT_W, emit a full word with out_last=0 as in REQ-021.
REQ-027 SHALL, in FLUSH with the slot free and fill<=OUT_W, emit out_data=acc[OUT_W-1:0] with bits at or above fill zeroed, out_bits=fill and out_last=1, clear fill and the accumulator, and return to RUN.
REQ-028 SHALL, when flushing with fill=0, emit a zero-length terminator word: out_data=0, out_bits=0, out_last=1.
REQ-029 SHALL guarantee that accumulator bits at or above fill are always zero.
REQ-030 SHALL drive idle = state==RUN && fill==0 && !out_valid.

Reset
REQ-031 SHALL, while rst=1, clear out_valid, out_data, out_bits, out_last, fill, and the accumulator, set state to RUN, and drive in_ready=0 and idle=0.
REQ-032 SHALL, on rst mid-stream or mid-flush, discard all buffered and pending bits with no partial word emitted; the first code after reset lands at bit 0.

Verification
REQ-033 SHALL verify: after reset, two 9-bit codes 0x100, 0x101, then flush, with out_ready=1 -> one word with out_data=0x20300, out_bits=18, out_last=1.
REQ-034 SHALL verify: five 13-bit codes 0x1FFF with out_ready=1 -> word with out_data=all ones, out_bits=64, out_last=0; then flush -> word with out_data=0x1, out_bits=1, out_last=1.
REQ-035 SHALL verify: out_ready=0 with 13-bit codes streaming -> the first word holds stable, and in_ready drops once fill>=64 with the slot full; raising out_ready drains with no bit lost or duplicated.
REQ-036 SHALL verify: flush with fill=0 -> a single word with out_bits=0, out_data=0, out_last=1; then idle=1.
REQ-037 SHALL verify: flush in the same cycle as an accepted 9-bit code 0x1AB into an empty packer -> out_data=0x1AB, out_bits=9, out_last=1.
REQ-038 SHALL verify: rst asserted during FLUSH with out_valid=1 -> next cycle out_valid=0 and out_bits=0; a following 9-bit code 0x155 plus flush -> out_data=0x155, out_bits=9.
